// File: rtl/polar_pkg.sv
// Shared constants, FSM state encoding and scatter helpers for the N=8 polar encoder.
// Build option POLAR_ENC_SYSTEMATIC_EN is handled in polar_encoder.sv.
package polar_pkg;

    localparam int N       = 8;
    localparam int LOG2N   = 3;
    localparam int STAGE_W = 2;
    localparam int POLAR_W = 20;
    localparam logic [POLAR_W-1:0] POLAR_LLR_MAG = 20'h01000;

    typedef logic [LOG2N-1:0] idx_t;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ENC  = 3'd1;
    localparam logic [2:0] ST_FRZ  = 3'd2;
    localparam logic [2:0] ST_MAP  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    function automatic int info_count(input logic [N-1:0] mask);
        int c;
        c = 0;
        for (int j = 0; j < N; j++) begin
            if (!mask[j]) c++;
        end
        return c;
    endfunction

    // Info bit i lands on the i-th lowest non-frozen index; frozen positions stay 0.
    function automatic logic [N-1:0] scatter(input logic [N-1:0] mask, input logic [N-1:0] info);
        logic [N-1:0] u;
        idx_t i;
        u = '0;
        i = '0;
        for (int j = 0; j < N; j++) begin
            if (!mask[j]) begin
                u[j] = info[i];
                i = i + idx_t'(1);
            end
        end
        return u;
    endfunction

endpackage

// File: rtl/polar_enc_stage.sv
// One combinational butterfly stage of u*F^(x3): x[j] ^= x[j+2^s] where bit s of j is clear.
module polar_enc_stage
    import polar_pkg::*;
(
    input  logic [N-1:0]       x,
    input  logic [STAGE_W-1:0] stage,
    output logic [N-1:0]       y
);

    logic [LOG2N-1:0] sbit;

    assign sbit = idx_t'(1) << stage;

    always_comb begin
        y = x;
        for (int j = 0; j < N; j++) begin
            if ((idx_t'(j) & sbit) == '0) begin
                y[j] = x[j] ^ x[idx_t'(j) | sbit];
            end
        end
    end

endmodule

// File: rtl/polar_encoder.sv
// N=8 polar encoder with BPSK LLR mapping, one butterfly stage per cycle.
// Define POLAR_ENC_SYSTEMATIC_EN for systematic encoding (second pass after freezing).
module polar_encoder
    import polar_pkg::*;
#(
    parameter int             W           = POLAR_W,
    parameter logic [W-1:0]   LLR_MAG     = W'(POLAR_LLR_MAG),
    parameter int             K           = 4,
    parameter logic [N-1:0]   FROZEN_MASK = 8'b0001_0111
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [K-1:0] msg,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] out0,
    output logic [W-1:0] out1,
    output logic [W-1:0] out2,
    output logic [W-1:0] out3,
    output logic [W-1:0] out4,
    output logic [W-1:0] out5,
    output logic [W-1:0] out6,
    output logic [W-1:0] out7,
    output logic [2:0]   state_dbg
);

    localparam logic [W-1:0] NEG_MAG = ~LLR_MAG + W'(1);

    if (K != info_count(FROZEN_MASK)) begin : g_bad_k
        $error("polar_encoder: K must equal the number of non-frozen positions");
    end

    logic [2:0]         state_q;
    logic [N-1:0]       x_q;
    logic [N-1:0]       x_stage;
    logic [N-1:0]       msg_ext;
    logic [STAGE_W-1:0] stage_q;
    logic [W-1:0]       outs_q [N];
`ifdef POLAR_ENC_SYSTEMATIC_EN
    logic               pass_q;
`endif

    assign msg_ext = N'(msg);

    polar_enc_stage u_stage (
        .x     (x_q),
        .stage (stage_q),
        .y     (x_stage)
    );

    // Valid/ready style: en is a request accepted only in IDLE or DONE; done is the
    // valid flag for out0..out7 and drops on the edge that accepts the next request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            stage_q <= '0;
`ifdef POLAR_ENC_SYSTEMATIC_EN
            pass_q  <= 1'b0;
`endif
            for (int j = 0; j < N; j++) outs_q[j] <= '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (en) begin
                        x_q     <= scatter(FROZEN_MASK, msg_ext);
                        stage_q <= '0;
`ifdef POLAR_ENC_SYSTEMATIC_EN
                        pass_q  <= 1'b0;
`endif
                        state_q <= ST_ENC;
                    end
                end
                ST_ENC: begin
                    x_q <= x_stage;
                    if (stage_q == STAGE_W'(LOG2N - 1)) begin
                        stage_q <= '0;
`ifdef POLAR_ENC_SYSTEMATIC_EN
                        state_q <= pass_q ? ST_MAP : ST_FRZ;
`else
                        state_q <= ST_MAP;
`endif
                    end else begin
                        stage_q <= stage_q + STAGE_W'(1);
                    end
                end
`ifdef POLAR_ENC_SYSTEMATIC_EN
                // Re-encoding after clearing frozen positions makes info indices carry msg.
                ST_FRZ: begin
                    x_q     <= x_q & ~FROZEN_MASK;
                    pass_q  <= 1'b1;
                    stage_q <= '0;
                    state_q <= ST_ENC;
                end
`endif
                ST_MAP: begin
                    for (int j = 0; j < N; j++) outs_q[j] <= x_q[j] ? NEG_MAG : LLR_MAG;
                    state_q <= ST_DONE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy      = (state_q == ST_ENC) || (state_q == ST_FRZ);
    assign done      = (state_q == ST_DONE);
    assign state_dbg = state_q;

    assign out0 = outs_q[0];
    assign out1 = outs_q[1];
    assign out2 = outs_q[2];
    assign out3 = outs_q[3];
    assign out4 = outs_q[4];
    assign out5 = outs_q[5];
    assign out6 = outs_q[6];
    assign out7 = outs_q[7];

endmodule
